// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared types for the 68030 bus initiator.
// SIZ codes, FSM states, port sizes, DSACK decode, size helpers.
package m68k_bus_pkg;

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_3B   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_TERM,
    S_RECOVER
  } state_e;

  typedef enum logic [1:0] {
    PNONE,
    P8,
    P16,
    P32
  } port_e;

  function automatic port_e dsack_decode(
    input logic ds1,
    input logic ds0
  );
    port_e p;
    unique case ({ds1, ds0})
      2'b00:   p = P32;
      2'b01:   p = P16;
      2'b10:   p = P8;
      default: p = PNONE;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] siz_bytes(
    input logic [1:0] siz
  );
    logic [2:0] b;
    unique case (siz)
      SIZ_BYTE: b = 3'd1;
      SIZ_WORD: b = 3'd2;
      SIZ_3B:   b = 3'd3;
      default:  b = 3'd4;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] siz_mask(
    input logic [1:0] siz
  );
    logic [31:0] m;
    unique case (siz)
      SIZ_BYTE: m = 32'h0000_00ff;
      SIZ_WORD: m = 32'h0000_ffff;
      SIZ_3B:   m = 32'h00ff_ffff;
      default:  m = 32'hffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/m68k_bus_initiator_if.sv
// m68k_bus_initiator_if: request side + 68030 bus signals.
// master = initiator view, slave = requester/responder view.
interface m68k_bus_initiator_if #(
  parameter int ADDR_W = 28
);
  logic              REQ;
  logic              REQ_RnW;
  logic [1:0]        REQ_SIZ;
  logic [ADDR_W-1:0] REQ_ADDR;
  logic [31:0]       REQ_WDATA;
  logic              BUSY;
  logic              DONE;
  logic [31:0]       RDATA;
  logic              ERR;
  logic              nAS;
  logic              nDS;
  logic              RnW;
  logic              SIZ1;
  logic              SIZ0;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       D_OUT;
  logic              D_OE;
  logic [31:0]       D_IN;
  logic              nDSACK1;
  logic              nDSACK0;
  logic              nBERR;

  modport master (
    input  REQ, REQ_RnW, REQ_SIZ,
    input  REQ_ADDR, REQ_WDATA,
    input  D_IN, nDSACK1, nDSACK0, nBERR,
    output BUSY, DONE, RDATA, ERR,
    output nAS, nDS, RnW, SIZ1, SIZ0,
    output ADDR, D_OUT, D_OE
  );

  modport slave (
    output REQ, REQ_RnW, REQ_SIZ,
    output REQ_ADDR, REQ_WDATA,
    output D_IN, nDSACK1, nDSACK0, nBERR,
    input  BUSY, DONE, RDATA, ERR,
    input  nAS, nDS, RnW, SIZ1, SIZ0,
    input  ADDR, D_OUT, D_OE
  );
endinterface

// File: rtl/m68k_lane_mux.sv
// m68k_lane_mux: byte count, write-lane replication, read extraction.
// In: a_i, rem_i, port_i, wdata_i, din_i. Out: lanes_o, n_o, rbytes_o.
module m68k_lane_mux
  import m68k_bus_pkg::*;
(
  input  logic [1:0]  a_i,
  input  logic [2:0]  rem_i,
  input  port_e       port_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] din_i,
  output logic [31:0] lanes_o,
  output logic [2:0]  n_o,
  output logic [31:0] rbytes_o
);

  logic [2:0]  w;
  logic [2:0]  off;
  logic [2:0]  avail;
  logic [31:0] rj;
  logic [1:0]  li;
  logic [1:0]  k;

  always_comb begin
    w   = 3'd1;
    off = 3'd0;
    unique case (port_i)
      P32: begin
        w   = 3'd4;
        off = {1'b0, a_i};
      end
      P16: begin
        w   = 3'd2;
        off = {2'b00, a_i[0]};
      end
      default: ;
    endcase
    avail = w - off;
    n_o   = (rem_i < avail) ? rem_i : avail;
  end

  // Port lanes start at the address offset within the port.
  always_comb begin
    rbytes_o = '0;
    li       = '0;
    for (int i = 0; i < 4; i++) begin
      li = off[1:0] + 2'(i);
      if (3'(i) < n_o)
        rbytes_o = {rbytes_o[23:0],
                    din_i[{~li, 3'b000} +: 8]};
    end
  end

  // Remaining bytes left-justified: byte k sits at rj lane k.
  always_comb begin
    rj      = wdata_i << {3'd4 - rem_i, 3'b000};
    lanes_o = '0;
    k       = '0;
    for (int l = 0; l < 4; l++) begin
      if (2'(l) >= a_i)
        k = 2'(l) - a_i;
      else
        k = a_i[0] ? 2'd0 : 2'(l % 2);
      lanes_o[{~2'(l), 3'b000} +: 8] =
        rj[{~k, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/m68k_bus_initiator.sv
// m68k_bus_initiator: 68030 bus master with dynamic bus sizing.
// Ports: CLK, nRST (sync low), bus (master). Option: BUS_TIMEOUT_EN.
module m68k_bus_initiator
  import m68k_bus_pkg::*;
#(
  parameter int ADDR_W         = 28,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                  CLK,
  input logic                  nRST,
  m68k_bus_initiator_if.master bus
);

  state_e            state_q, state_d;
  logic              rnw_q, rnw_d;
  logic [1:0]        siz_q, siz_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        rem_q, rem_d;
  logic [31:0]       acc_q, acc_d;
  port_e             psz_q, psz_d;
  logic              berr_q, berr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  port_e       port_live;
  port_e       port_sel;
  logic [31:0] lanes;
  logic [2:0]  n;
  logic [31:0] rbytes;
  logic        tmo;
  logic        drive;

  assign port_live = dsack_decode(bus.nDSACK1,
                                  bus.nDSACK0);
  // Live decode while waiting; latched size in TERM.
  assign port_sel = (state_q == S_WAIT) ?
                    port_live : psz_q;

  m68k_lane_mux u_mux (
    .a_i      (addr_q[1:0]),
    .rem_i    (rem_q),
    .port_i   (port_sel),
    .wdata_i  (wdata_q),
    .din_i    (bus.D_IN),
    .lanes_o  (lanes),
    .n_o      (n),
    .rbytes_o (rbytes)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge CLK) begin
    if (!nRST)
      cnt_q <= '0;
    else if (state_q == S_SETUP)
      cnt_q <= '0;
    else if (state_q == S_WAIT)
      cnt_q <= cnt_q + 1'b1;
  end
  assign tmo = (state_q == S_WAIT) &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo        = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      rnw_q   <= 1'b1;
      siz_q   <= SIZ_LONG;
      addr_q  <= '0;
      wdata_q <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      psz_q   <= PNONE;
      berr_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rnw_q   <= rnw_d;
      siz_q   <= siz_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      psz_q   <= psz_d;
      berr_q  <= berr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rnw_d   = rnw_q;
    siz_d   = siz_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    psz_d   = psz_q;
    berr_d  = berr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.REQ) begin
          state_d = S_SETUP;
          rnw_d   = bus.REQ_RnW;
          siz_d   = bus.REQ_SIZ;
          addr_d  = bus.REQ_ADDR;
          wdata_d = bus.REQ_WDATA;
          rem_d   = siz_bytes(bus.REQ_SIZ);
          acc_d   = '0;
          berr_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_SETUP:  state_d = S_STROBE;
      S_STROBE: state_d = S_WAIT;
      S_WAIT: begin
        // Bus error beats a simultaneous DSACK.
        if (!bus.nBERR ||
            (tmo && port_live == PNONE)) begin
          berr_d  = 1'b1;
          state_d = S_TERM;
        end else if (port_live != PNONE) begin
          psz_d   = port_live;
          state_d = S_TERM;
          if (rnw_q)
            acc_d = (acc_q << {n, 3'b000}) | rbytes;
        end
      end
      S_TERM: begin
        state_d = S_RECOVER;
        if (!berr_q) begin
          addr_d = addr_q + ADDR_W'(n);
          rem_d  = rem_q - n;
        end
      end
      S_RECOVER: begin
        if (bus.nDSACK1 && bus.nDSACK0) begin
          if (!berr_q && rem_q != 3'd0) begin
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            err_d   = berr_q;
            rdata_d = berr_q ? 32'h0 :
                      (acc_q & siz_mask(siz_q));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign drive = !rnw_q &&
                 (state_q inside {S_SETUP, S_STROBE,
                                  S_WAIT, S_TERM});

  assign bus.nAS   = !(state_q inside {S_STROBE, S_WAIT});
  assign bus.nDS   = !(state_q inside {S_STROBE, S_WAIT});
  assign bus.RnW   = rnw_q;
  assign bus.SIZ1  = rem_q[1];
  assign bus.SIZ0  = rem_q[0];
  assign bus.ADDR  = addr_q;
  assign bus.D_OE  = drive;
  assign bus.D_OUT = drive ? lanes : 32'h0;
  assign bus.BUSY  = busy_q;
  assign bus.DONE  = done_q;
  assign bus.ERR   = err_q;
  assign bus.RDATA = rdata_q;

endmodule

// File: tb/tb_m68k_bus_initiator.sv
// tb_m68k_bus_initiator: directed bench with responder model
// and cycle/result scoreboard queues.
module tb_m68k_bus_initiator;
  import m68k_bus_pkg::*;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  m68k_bus_initiator_if #(.ADDR_W(28)) bus ();

  m68k_bus_initiator #(
    .ADDR_W         (28),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic [27:0] addr;
    logic [1:0]  siz;
    logic        has_lane;
    logic [1:0]  lidx;
    logic [7:0]  lane;
  } cyc_t;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        err;
  } res_t;

  cyc_t cq[$];
  res_t rq[$];
  logic [7:0] mem [logic [27:0]];
  int total = 0;
  int bad = 0;
  int lat;
  bit saw;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] memrd(
    input logic [27:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] rd_model(
    input logic [27:0] a, input int nb);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nb; i++)
      v = {v[23:0], memrd(a + 28'(i))};
    return v;
  endfunction

  task automatic pc(input logic [27:0] a,
                    input logic [1:0] s);
    cyc_t c;
    c.addr = a; c.siz = s; c.has_lane = 1'b0;
    c.lidx = 2'd0; c.lane = 8'h00;
    cq.push_back(c);
  endtask

  task automatic pcl(input logic [27:0] a,
                     input logic [1:0] s,
                     input logic [1:0] li,
                     input logic [7:0] v);
    cyc_t c;
    c.addr = a; c.siz = s; c.has_lane = 1'b1;
    c.lidx = li; c.lane = v;
    cq.push_back(c);
  endtask

  task automatic pr(input logic cr,
                    input logic [31:0] d,
                    input logic e);
    res_t r;
    r.chk_rd = cr; r.rdata = d; r.err = e;
    rq.push_back(r);
  endtask

  // Responder: port32 full lanes, port16 on D31:16, port8 on D31:24.
  task automatic respond(input int pb);
    logic [27:0] a;
    logic [31:0] d;
    a = bus.ADDR;
    d = 32'h5A5A5A5A;
    if (pb == 4) begin
      for (int l = 0; l < 4; l++)
        d[{~2'(l), 3'b000} +: 8] =
          memrd({a[27:2], 2'(l)});
      bus.nDSACK1 = 1'b0;
      bus.nDSACK0 = 1'b0;
    end else if (pb == 2) begin
      d[31:24] = memrd({a[27:1], 1'b0});
      d[23:16] = memrd({a[27:1], 1'b1});
      bus.nDSACK1 = 1'b0;
    end else begin
      d[31:24] = memrd(a);
      bus.nDSACK0 = 1'b0;
    end
    bus.D_IN = d;
  endtask

  task automatic run(input logic rnw,
                     input logic [1:0] siz,
                     input logic [27:0] a,
                     input logic [31:0] wd,
                     input int pb,
                     input int wt,
                     input int bp,
                     input bit poke,
                     output int lt);
    bit done;
    bit seen;
    int cnt;
    int piece;
    int g;
    cyc_t c;
    res_t r;
    done = 0; seen = 0; cnt = 0;
    piece = 0; g = 0;
    @(negedge clk);
    bus.REQ = 1'b1;
    bus.REQ_RnW = rnw;
    bus.REQ_SIZ = siz;
    bus.REQ_ADDR = a;
    bus.REQ_WDATA = wd;
    @(negedge clk);
    bus.REQ = 1'b0;
    bus.REQ_ADDR = 28'h0AAAAAA;
    bus.REQ_WDATA = 32'h0;
    chk("busy_set", bus.BUSY, 1);
    lt = 1;
    while (!done && g < 300) begin
      if (!bus.nAS) begin
        if (!seen) begin
          seen = 1;
          cnt = 0;
          if (cq.size() == 0) begin
            chk("extra_cycle", 1, 0);
          end else begin
            c = cq.pop_front();
            chk("cyc_addr", bus.ADDR, c.addr);
            chk("cyc_siz", {bus.SIZ1, bus.SIZ0}, c.siz);
            chk("cyc_oe", bus.D_OE, !rnw);
            if (c.has_lane)
              chk("cyc_lane",
                  bus.D_OUT[{~c.lidx, 3'b000} +: 8],
                  c.lane);
          end
        end
        cnt++;
        if (cnt == wt + 1) begin
          if (piece == bp) begin
            bus.nBERR = 1'b0;
            bus.nDSACK0 = 1'b0;
          end else begin
            respond(pb);
          end
        end
      end else begin
        bus.nDSACK1 = 1'b1;
        bus.nDSACK0 = 1'b1;
        bus.nBERR = 1'b1;
        if (seen) begin
          seen = 0;
          piece++;
        end
      end
      if (poke) bus.REQ = (g == 3);
      @(negedge clk);
      g++;
      lt++;
      if (bus.DONE) begin
        done = 1;
        if (rq.size() == 0) begin
          chk("extra_done", 1, 0);
        end else begin
          r = rq.pop_front();
          chk("err", bus.ERR, r.err);
          if (r.chk_rd)
            chk("rdata", bus.RDATA, r.rdata);
          chk("busy_clr", bus.BUSY, 0);
          chk("leftover_cycles", cq.size(), 0);
        end
      end
    end
    bus.REQ = 1'b0;
    bus.nDSACK1 = 1'b1;
    bus.nDSACK0 = 1'b1;
    bus.nBERR = 1'b1;
    if (!done) begin
      chk("done_timeout", 0, 1);
      cq.delete();
      rq.delete();
    end
  endtask

  initial begin
    bus.REQ = 1'b0;
    bus.REQ_RnW = 1'b1;
    bus.REQ_SIZ = 2'b00;
    bus.REQ_ADDR = '0;
    bus.REQ_WDATA = '0;
    bus.D_IN = '0;
    bus.nDSACK1 = 1'b1;
    bus.nDSACK0 = 1'b1;
    bus.nBERR = 1'b1;
    nrst = 1'b0;

    mem[28'h100] = 8'h11; mem[28'h101] = 8'h22;
    mem[28'h102] = 8'h33; mem[28'h103] = 8'h44;
    mem[28'h104] = 8'h55; mem[28'h105] = 8'h66;
    mem[28'h002] = 8'hBE; mem[28'h003] = 8'hEF;
    mem[28'h000] = 8'h81;
    mem[28'h300] = 8'h99; mem[28'h301] = 8'hA1;
    mem[28'h302] = 8'hB2; mem[28'h303] = 8'hC3;
    mem[28'h400] = 8'hCA; mem[28'h401] = 8'hFE;
    mem[28'h402] = 8'hF0; mem[28'h403] = 8'h0D;
    mem[28'hFFFFFFF] = 8'h7E;
    mem[28'h200] = 8'hD0; mem[28'h201] = 8'hD1;
    mem[28'h202] = 8'hD2; mem[28'h203] = 8'hD3;

    repeat (3) @(negedge clk);
    chk("rst_nas", bus.nAS, 1);
    chk("rst_nds", bus.nDS, 1);
    chk("rst_rnw", bus.RnW, 1);
    chk("rst_siz", {bus.SIZ1, bus.SIZ0}, 0);
    chk("rst_addr", bus.ADDR, 0);
    chk("rst_oe", bus.D_OE, 0);
    chk("rst_dout", bus.D_OUT, 0);
    chk("rst_flags",
        {bus.BUSY, bus.DONE, bus.ERR}, 0);
    chk("rst_rdata", bus.RDATA, 0);
    nrst = 1'b1;

    pc(28'h400, 2'b00);
    pr(1, rd_model(28'h400, 4), 0);
    run(1, SIZ_LONG, 28'h400, 0, 4, 0, -1, 0, lat);
    chk("latency", lat, 6);
    @(negedge clk);
    chk("done_pulse", bus.DONE, 0);

    pc(28'h100, 2'b00);
    pr(1, 32'h11223344, 0);
    run(1, SIZ_LONG, 28'h100, 0, 4, 2, -1, 0, lat);

    pcl(28'h101, 2'b00, 2'd0, 8'hAA);
    pcl(28'h102, 2'b11, 2'd0, 8'hBB);
    pcl(28'h103, 2'b10, 2'd0, 8'hCC);
    pcl(28'h104, 2'b01, 2'd0, 8'hDD);
    pr(0, 0, 0);
    run(0, SIZ_LONG, 28'h101, 32'hAABBCCDD,
        1, 1, -1, 0, lat);

    pcl(28'h003, 2'b10, 2'd1, 8'h12);
    pcl(28'h004, 2'b01, 2'd0, 8'h34);
    pr(0, 0, 0);
    run(0, SIZ_WORD, 28'h003, 32'h00001234,
        2, 0, -1, 0, lat);

    pcl(28'h003, 2'b10, 2'd1, 8'h12);
    pcl(28'h004, 2'b01, 2'd0, 8'h34);
    pr(0, 0, 0);
    run(0, SIZ_WORD, 28'h003, 32'h00001234,
        4, 1, -1, 0, lat);

    pc(28'h002, 2'b10);
    pr(1, 32'h0000BEEF, 0);
    run(1, SIZ_WORD, 28'h002, 0, 2, 0, -1, 0, lat);

    pc(28'h301, 2'b11);
    pr(1, 32'h00A1B2C3, 0);
    run(1, SIZ_3B, 28'h301, 0, 4, 0, -1, 0, lat);

    pc(28'h103, 2'b01);
    pr(1, rd_model(28'h103, 1), 0);
    run(1, SIZ_BYTE, 28'h103, 0, 2, 0, -1, 0, lat);

    pc(28'h102, 2'b00);
    pc(28'h104, 2'b10);
    pr(1, rd_model(28'h102, 4), 0);
    run(1, SIZ_LONG, 28'h102, 0, 2, 2, -1, 1, lat);

    pc(28'hFFFFFFF, 2'b10);
    pc(28'h0000000, 2'b01);
    pr(1, 32'h00007E81, 0);
    run(1, SIZ_WORD, 28'hFFFFFFF, 0, 1, 0, -1, 0, lat);

    pc(28'h200, 2'b00);
    pc(28'h201, 2'b11);
    pr(1, 32'h0, 1);
    run(1, SIZ_LONG, 28'h200, 0, 1, 0, 1, 0, lat);
    repeat (3) @(negedge clk);
    chk("err_held", bus.ERR, 1);
    chk("err_rdata", bus.RDATA, 0);

    pc(28'h100, 2'b01);
    pr(1, 32'h00000011, 0);
    run(1, SIZ_BYTE, 28'h100, 0, 4, 0, -1, 0, lat);

`ifdef BUS_TIMEOUT_EN
    pc(28'h500, 2'b00);
    pr(1, 32'h0, 1);
    run(1, SIZ_LONG, 28'h500, 0, 4, 100, -1, 0, lat);
`endif

    @(negedge clk);
    bus.REQ = 1'b1;
    bus.REQ_RnW = 1'b1;
    bus.REQ_SIZ = SIZ_LONG;
    bus.REQ_ADDR = 28'h600;
    @(negedge clk);
    bus.REQ = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_nas_pre", bus.nAS, 0);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_mid_nas", bus.nAS, 1);
    chk("rst_mid_busy", bus.BUSY, 0);
    chk("rst_mid_addr", bus.ADDR, 0);
    nrst = 1'b1;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.DONE) saw = 1;
    end
    chk("rst_mid_no_done", saw, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
